// File: rtl/vx_warp_barrier_table.sv
// Per-core warp barrier table: tracks arrivals per barrier ID and
// releases all parked warps in one registered pulse when complete.
module vx_warp_barrier_table #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 8,
    localparam int WB = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int BB = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bar_valid,
    input  logic [BB-1:0]        bar_id,
    input  logic [WB-1:0]        bar_wid,
    input  logic [WB-1:0]        bar_size_m1,
    input  logic                 kill_valid,
    input  logic [WB-1:0]        kill_wid,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic [NUM_WARPS-1:0] waiting_mask,
    output logic                 bar_error
);

    typedef struct packed {
        logic                 active;
        logic [WB-1:0]        size_m1;
        logic [WB:0]          count;
        logic [NUM_WARPS-1:0] mask;
    } entry_t;

    entry_t tbl_q [NUM_BARRIERS];
    entry_t tbl_d [NUM_BARRIERS];
    entry_t sel;
    entry_t upd;

    logic [NUM_WARPS-1:0] wid_bit;
    logic [NUM_WARPS-1:0] kill_bit;
    logic [NUM_WARPS-1:0] post_wait;
    logic [NUM_WARPS-1:0] nxt_wait;
    logic [NUM_WARPS-1:0] rel_m;
    logic                 rel_v;
    logic                 in_range;
    logic                 dup;
    logic                 drop;
    logic                 err;
    logic                 arr_ok;
    logic                 sel_full;

    always_comb begin
        tbl_d    = tbl_q;
        wid_bit  = NUM_WARPS'(1) << bar_wid;
        kill_bit = NUM_WARPS'(1) << kill_wid;

        // Kill is applied first so the arrival sees the post-kill table.
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (kill_valid && tbl_d[b].active &&
                (|(tbl_d[b].mask & kill_bit))) begin
                tbl_d[b].mask  = tbl_d[b].mask & ~kill_bit;
                tbl_d[b].count = tbl_d[b].count - (WB+1)'(1);
                if (tbl_d[b].count == '0) begin
                    tbl_d[b] = '0;
                end
            end
        end

        post_wait = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            post_wait = post_wait | tbl_d[b].mask;
        end

        in_range = int'(bar_id) < NUM_BARRIERS;
        dup      = |(post_wait & wid_bit);
        drop     = bar_valid && kill_valid && (kill_wid == bar_wid);
        err      = bar_valid && !drop && (!in_range || dup);
        arr_ok   = bar_valid && !drop && !err;

        sel = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (BB'(b) == bar_id) begin
                sel = tbl_d[b];
            end
        end
        sel_full = (sel.count == {1'b0, sel.size_m1});

        rel_v = 1'b0;
        rel_m = '0;
        upd   = sel;
        if (arr_ok) begin
            unique case (1'b1)
                !sel.active && (bar_size_m1 == '0): begin
                    rel_v = 1'b1;
                    rel_m = wid_bit;
                end
                !sel.active && (bar_size_m1 != '0): begin
                    upd.active  = 1'b1;
                    upd.size_m1 = bar_size_m1;
                    upd.count   = (WB+1)'(1);
                    upd.mask    = wid_bit;
                end
                sel.active && sel_full: begin
                    rel_v = 1'b1;
                    rel_m = sel.mask | wid_bit;
                    upd   = '0;
                end
                sel.active && !sel_full: begin
                    upd.count = sel.count + (WB+1)'(1);
                    upd.mask  = sel.mask | wid_bit;
                end
                default: begin
                    upd = sel;
                end
            endcase
        end

        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (arr_ok && (BB'(b) == bar_id)) begin
                tbl_d[b] = upd;
            end
        end

        nxt_wait = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            nxt_wait = nxt_wait | tbl_d[b].mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                tbl_q[b] <= '0;
            end
            release_valid <= 1'b0;
            release_mask  <= '0;
            waiting_mask  <= '0;
            bar_error     <= 1'b0;
        end else begin
            tbl_q         <= tbl_d;
            release_valid <= rel_v;
            release_mask  <= rel_m;
            waiting_mask  <= nxt_wait;
            bar_error     <= err;
        end
    end

endmodule

// File: tb/tb_vx_warp_barrier_table.sv
// Directed vector bench for vx_warp_barrier_table.
// Each row is driven for one cycle; outputs are compared after the edge.
module tb_vx_warp_barrier_table;

    logic       clk = 1'b0;
    logic       reset;
    logic       bar_valid;
    logic [2:0] bar_id;
    logic [1:0] bar_wid;
    logic [1:0] bar_size_m1;
    logic       kill_valid;
    logic [1:0] kill_wid;
    logic       release_valid;
    logic [3:0] release_mask;
    logic [3:0] waiting_mask;
    logic       bar_error;

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;

    vx_warp_barrier_table #(.NUM_WARPS(4), .NUM_BARRIERS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bar_valid    (bar_valid),
        .bar_id       (bar_id),
        .bar_wid      (bar_wid),
        .bar_size_m1  (bar_size_m1),
        .kill_valid   (kill_valid),
        .kill_wid     (kill_wid),
        .release_valid(release_valid),
        .release_mask (release_mask),
        .waiting_mask (waiting_mask),
        .bar_error    (bar_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       bv;
        logic [2:0] id;
        logic [1:0] wid;
        logic [1:0] sz;
        logic       kv;
        logic [1:0] kw;
        logic       rv;
        logic [3:0] rm;
        logic [3:0] wm;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic rst, input logic bv,
                       input logic [2:0] id, input logic [1:0] wid,
                       input logic [1:0] sz, input logic kv,
                       input logic [1:0] kw, input logic rv,
                       input logic [3:0] rm, input logic [3:0] wm,
                       input logic err);
        vec_t v;
        v.name = n; v.rst = rst; v.bv = bv; v.id = id; v.wid = wid;
        v.sz = sz; v.kv = kv; v.kw = kw; v.rv = rv; v.rm = rm;
        v.wm = wm; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [9:0] exp);
        logic [9:0] got;
        got = {release_valid, release_mask, waiting_mask, bar_error};
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got rv/rm/wm/err=%b expected %b", n, got, exp);
    endtask

    // Output invariants checked every cycle once reset has been applied.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (release_valid || release_mask == 4'b0000) passed++;
            else $display("FAIL hold_zero got rm=%b expected 0000", release_mask);
            total++;
            if ((waiting_mask & release_mask) == 4'b0000) passed++;
            else $display("FAIL wait_excl got wm=%b rm=%b expected disjoint",
                          waiting_mask, release_mask);
        end
    end

    initial begin
        reset = 1'b0; bar_valid = 1'b0; bar_id = '0; bar_wid = '0;
        bar_size_m1 = '0; kill_valid = 1'b0; kill_wid = '0;

        //   name        rst bv id wid sz kv kw  rv rm       wm       err
        add("reset",      1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add("b4_w0",      0, 1, 3, 0, 3, 0, 0, 0, 4'b0000, 4'b0001, 0);
        add("b4_w2",      0, 1, 3, 2, 3, 0, 0, 0, 4'b0000, 4'b0101, 0);
        add("b4_w1",      0, 1, 3, 1, 3, 0, 0, 0, 4'b0000, 4'b0111, 0);
        add("b4_rel",     0, 1, 3, 3, 3, 0, 0, 1, 4'b1111, 4'b0000, 0);
        add("b4_idle",    0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add("single",     0, 1, 0, 2, 0, 0, 0, 1, 4'b0100, 4'b0000, 0);
        add("single_idle",0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add("dup_first",  0, 1, 5, 1, 2, 0, 0, 0, 4'b0000, 4'b0010, 0);
        add("dup_err",    0, 1, 6, 1, 2, 0, 0, 0, 4'b0000, 4'b0010, 1);
        add("dup_idle",   0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 0);
        add("b6_w3",      0, 1, 6, 3, 1, 0, 0, 0, 4'b0000, 4'b1010, 0);
        add("b6_rel",     0, 1, 6, 0, 1, 0, 0, 1, 4'b1001, 4'b0010, 0);
        add("kill_last",  0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0);
        add("k_w0",       0, 1, 2, 0, 2, 0, 0, 0, 4'b0000, 4'b0001, 0);
        add("k_w1",       0, 1, 2, 1, 2, 0, 0, 0, 4'b0000, 4'b0011, 0);
        add("k_kill0",    0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0010, 0);
        add("k_w2",       0, 1, 2, 2, 2, 0, 0, 0, 4'b0000, 4'b0110, 0);
        add("k_rel",      0, 1, 2, 3, 2, 0, 0, 1, 4'b1110, 4'b0000, 0);
        add("sk_w0",      0, 1, 4, 0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0);
        add("sk_same",    0, 1, 4, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("sk_w3",      0, 1, 4, 3, 1, 0, 0, 0, 4'b0000, 4'b1000, 0);
        add("sk_rel",     0, 1, 4, 2, 1, 0, 0, 1, 4'b1100, 4'b0000, 0);
        add("so_w0",      0, 1, 5, 0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0);
        add("so_kill",    0, 1, 5, 1, 1, 1, 0, 0, 4'b0000, 4'b0010, 0);
        add("so_clean",   0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0);
        add("rs_w0",      0, 1, 1, 0, 2, 0, 0, 0, 4'b0000, 4'b0001, 0);
        add("rs_w1",      0, 1, 1, 1, 2, 0, 0, 0, 4'b0000, 4'b0011, 0);
        add("rs_reset",   1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        add("rs_w2",      0, 1, 1, 2, 1, 0, 0, 0, 4'b0000, 4'b0100, 0);
        add("rs_rel",     0, 1, 1, 3, 1, 0, 0, 1, 4'b1100, 4'b0000, 0);
        add("szm_w0",     0, 1, 2, 0, 3, 0, 0, 0, 4'b0000, 4'b0001, 0);
        add("szm_w1",     0, 1, 2, 1, 0, 0, 0, 0, 4'b0000, 4'b0011, 0);
        add("szm_w2",     0, 1, 2, 2, 1, 0, 0, 0, 4'b0000, 4'b0111, 0);
        add("szm_rel",    0, 1, 2, 3, 1, 0, 0, 1, 4'b1111, 4'b0000, 0);
        add("samebar_w2", 0, 1, 3, 2, 2, 0, 0, 0, 4'b0000, 4'b0100, 0);
        add("samebar_dup",0, 1, 3, 2, 2, 0, 0, 0, 4'b0000, 4'b0100, 1);
        add("kill_other", 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0100, 0);
        add("samebar_k",  0, 0, 0, 0, 0, 1, 2, 0, 4'b0000, 4'b0000, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset       = vecs[i].rst;
            bar_valid   = vecs[i].bv;
            bar_id      = vecs[i].id;
            bar_wid     = vecs[i].wid;
            bar_size_m1 = vecs[i].sz;
            kill_valid  = vecs[i].kv;
            kill_wid    = vecs[i].kw;
            @(posedge clk);
            #1;
            check(vecs[i].name, {vecs[i].rv, vecs[i].rm, vecs[i].wm, vecs[i].err});
            mon_en = 1'b1;
        end

        // Entry reuse right after release, and a release on another entry
        // in the very next cycle.
        @(negedge clk);
        reset = 1'b0; kill_valid = 1'b0;
        bar_valid = 1'b1; bar_id = 3'd7; bar_wid = 2'd0; bar_size_m1 = 2'd1;
        @(negedge clk);
        bar_wid = 2'd1;
        @(negedge clk);
        check("reuse_rel", {1'b1, 4'b0011, 4'b0000, 1'b0});
        bar_wid = 2'd2;
        @(negedge clk);
        check("reuse_first", {1'b0, 4'b0000, 4'b0100, 1'b0});
        bar_id = 3'd0; bar_wid = 2'd3; bar_size_m1 = 2'd0;
        @(negedge clk);
        check("other_single", {1'b1, 4'b1000, 4'b0100, 1'b0});
        bar_id = 3'd7; bar_wid = 2'd0; bar_size_m1 = 2'd1;
        @(negedge clk);
        check("reuse_rel2", {1'b1, 4'b0101, 4'b0000, 1'b0});

        // Reset arriving together with a completing arrival yields no release.
        bar_id = 3'd1; bar_wid = 2'd0; bar_size_m1 = 2'd1;
        @(negedge clk);
        reset = 1'b1; bar_wid = 2'd1;
        @(negedge clk);
        check("reset_vs_rel", {1'b0, 4'b0000, 4'b0000, 1'b0});
        reset = 1'b0; bar_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {1'b0, 4'b0000, 4'b0000, 1'b0});

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vx_warp_barrier_table.md
# vx_warp_barrier_table

Per-core barrier tracker that consumes the barrier requests emitted on the SFU's warp-control path.
- It records which warps have arrived at each barrier ID.
- When the expected number of warps has arrived, it releases them all at once by returning a one-cycle release mask to the warp scheduler.
- It sits between the SFU warp-control output and the scheduler's stall/unstall logic.
- It also lets the scheduler remove a killed warp from any pending barrier.

## Interface
Parameters:
- NUM_WARPS, 4: warps per core; warp ID width WB = max(1, clog2(NUM_WARPS)).
- NUM_BARRIERS, 8: barrier table entries; barrier ID width BB = max(1, clog2(NUM_BARRIERS)).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- bar_valid  in  1  barrier arrival request; one per cycle, no backpressure.
- bar_id  in  BB  barrier index.
- bar_wid  in  WB  arriving warp.
- bar_size_m1  in  WB  expected warp count minus 1.
- kill_valid  in  1  remove warp kill_wid from every barrier.
- kill_wid  in  WB  warp being killed.
- release_valid  out  1  registered one-cycle pulse; release_mask is valid.
- release_mask  out  NUM_WARPS  warps to unstall.
- waiting_mask  out  NUM_WARPS  warps currently parked at any barrier (registered).
- bar_error  out  1  registered one-cycle pulse on an illegal arrival.

## Operation
- Each entry b holds:
  - active flag;
  - size_m1 (WB bits), latched from the first arrival;
  - count (WB+1 bits), the number of arrivals;
  - mask (NUM_WARPS bits).
- Arrival at an inactive entry:
  - If bar_size_m1 == 0: release immediately with release_mask = onehot(bar_wid); the entry stays inactive.
  - Otherwise: set active, latch size_m1, set count = 1, set mask = onehot(bar_wid).
- Arrival at an active entry:
  - If count == size_m1: release mask | onehot(bar_wid), then clear the entry (active = 0, count = 0, mask = 0).
  - Otherwise: increment count and OR in the warp bit.
  - A bar_size_m1 that differs from the latched size_m1 is ignored; the latched value governs.
- Illegal arrivals (drop the request, pulse bar_error, leave the table unchanged):
  - bar_wid is already set in waiting_mask (on any barrier);
  - bar_id >= NUM_BARRIERS.
- Kill: for every active entry whose mask contains kill_wid:
  - clear that bit and decrement count;
  - if count reaches 0, clear the entry.
  - A kill never produces a release.
- Simultaneous arrival and kill in the same cycle:
  - The kill is applied first.
  - The arrival then sees the post-kill entry state.
  - If kill_wid == bar_wid, the arrival is dropped without bar_error.
- waiting_mask is the OR of all entry masks. It must never contain a warp that is in the current release_mask.

## Timing
- Reset values:
  - all entries inactive, count 0, mask 0;
  - release_valid = 0, release_mask = 0, waiting_mask = 0, bar_error = 0.
- Latency:
  - A completing arrival at cycle N gives release_valid = 1 at cycle N+1.
  - In that same N+1 cycle, waiting_mask already excludes the released warps.
- Non-completing arrival at cycle N: the warp bit appears in waiting_mask at N+1.
- Output hold rules:
  - release_mask is 0 whenever release_valid = 0.
  - At most one release per cycle, because there is at most one arrival per cycle.
- Reset asserted mid-barrier: all pending state is discarded at the next edge and no release is emitted. The scheduler re-initialises the stalled warps.
- Back-to-back operation:
  - An entry cleared at cycle N accepts a new first arrival at cycle N+1.
  - An arrival at cycle N+1 to a different entry is independent of the release in flight.

## Test plan
- **Basic 4-warp barrier.** NUM_WARPS=4, bar_id=3, size_m1=3; arrivals from wid 0, 2, 1, 3 on consecutive cycles.
  - waiting_mask steps 0001 → 0101 → 0111.
  - Cycle after the 4th arrival: release_valid=1, release_mask=1111, waiting_mask=0000.
- **Single-warp barrier.** size_m1=0, wid 2, bar_id 0 → the next cycle gives release_valid=1, release_mask=0100, and waiting_mask stays 0.
- **Duplicate arrival.** wid 1 arrives at bar 5 (size_m1=2), then wid 1 arrives at bar 6.
  - bar_error pulses once.
  - Bar 6 stays inactive; waiting_mask stays 0010.
- **Kill.** wids 0 and 1 wait on bar 2 (size_m1=2); kill wid 0.
  - waiting_mask becomes 0010.
  - Arrivals of wid 2 then wid 3 complete the barrier with release_mask=1110.
- **Simultaneous kill and arrival.** wid 0 waits on bar 4 (size_m1=1); in one cycle, kill wid 0 and an arrival from wid 0 at bar 4.
  - Entry is cleared; no release and no error.
  - A later arrival from wid 3 only leaves waiting_mask=1000.
- **Reset mid-barrier.** Reset with waiting_mask=0011 → all outputs are 0 the next cycle; a fresh 2-warp barrier then completes normally.
